uart_tx_datapath: RTL and testbench
===================================

// Module: uart_tx_datapath
// PURPOSE
//   UART transmit datapath, driven directly by fsm_tx: fsm_tx's ser_en/mux_sel/busy feed it, and its ser_done feeds back.
//   Captures the parallel word and computes parity. Serializes LSB-first and drives the registered TX line.
// PARAMETERS
//   DATA_WIDTH  8  payload bits per frame; legal range 2..16
// PORTS
//   clk         in   1           system clock; all logic on rising edge
//   rst         in   1           reset, synchronous, active-low
//   p_data      in   DATA_WIDTH  parallel word to send
//   data_valid  in   1           p_data valid this cycle
//   par_en      in   1           1 = parity bit in frame
//   par_typ     in   1           0 = even parity, 1 = odd parity
//   busy        in   1           from FSM: frame in progress
//   ser_en      in   1           from FSM: serializer enable
//   mux_sel     in   2           from FSM: 0 start, 1 stop/idle, 2 data, 3 parity
//   ser_done    out  1           to FSM: last data bit is on the line this cycle
//   par_en_q    out  1           latched par_en, routed to FSM par_en
//   tx_out      out  1           serial line, registered
// BEHAVIOUR
//   Reset: rst sampled low at a clk edge gives:
//     tx_out=1, shift_reg=0, bit_cnt=0, par_bit=0, par_en_q=0, ser_done=0.
//     Applies mid-frame too: line returns to idle-high on that edge and the frame is discarded.
//   Capture: on an edge with data_valid=1 && busy=0:
//     shift_reg<=p_data.
//     par_bit<=^p_data^par_typ (even: XOR of bits; odd: inverted).
//     par_en_q<=par_en; bit_cnt<=0.
//     data_valid while busy=1 is ignored and leaves the word, parity and config untouched.
//   Serialize: shift only when ser_en=1 && mux_sel==2.
//     Each such edge: shift_reg>>=1 (MSB filled 0), bit_cnt<=bit_cnt+1.
//     ser_en=1 with mux_sel==0 (start cycle): no shift, bit_cnt forced to 0.
//     ser_en=0 or mux_sel!=2: shift_reg and bit_cnt hold.
//   ser_done: combinational = (mux_sel==2) && ser_en && (bit_cnt==DATA_WIDTH-1).
//     Goes high during the cycle the final data bit is selected, so the FSM leaves the data state at the next edge.
//   bit_cnt: width $clog2(DATA_WIDTH)+1.
//     Saturates at DATA_WIDTH-1 while ser_done is held and never wraps.
//     It is cleared by the next capture or start cycle.
//   Output mux (combinational select, then registered):
//     mux_sel 0->0, 1->1, 2->shift_reg[0], 3->par_bit; tx_out<=selected bit each edge.
//     Latency: tx_out reflects mux_sel one clk later. All fields see the same latency, so bit widths are uniform.
//   Frame on line (par_en_q=1): start(0), D0..D{N-1}, parity, stop(1); each bit 1 clk.
//   Frame without parity: same frame with the parity bit omitted.
//   Simultaneous capture and shift: impossible, since capture needs busy=0 and shifting only occurs while busy=1.
//     If it happens anyway, capture wins.
//   Back-to-back: a new capture is accepted on the first edge after busy drops.
// TESTING
//   1. Even parity: DATA_WIDTH=8, p_data=0xA5, par_en=1, par_typ=0, with fsm_tx.
//      -> tx_out: 1,0,1,0,1,0,0,1,0,1,0,1,1 (idle,start,D0..D7,par=0,stop,idle).
//      -> ser_done high for 1 clk on bit D7.
//   2. Odd parity: p_data=0x01, par_en=1, par_typ=1.
//      -> parity bit=0, frame length 11 clks start to stop.
//   3. No parity: p_data=0xFF, par_en=0.
//      -> start, eight 1s, stop; no parity slot; busy drops after 10 bit-clks.
//   4. Busy guard: p_data=0x3C is sent; then data_valid with 0xC3 is pulsed mid-data.
//      -> the line carries only 0x3C; 0xC3 is dropped.
//   5. Reset mid-frame: rst=0 during D3.
//      -> tx_out=1 at the next edge and all state is zero.
//      -> after release, a fresh 0x5A frame is correct.
//   6. Stall: hold ser_en=0 for 3 clks with mux_sel=2 on D4 (forced FSM).
//      -> tx_out holds D4, bit_cnt holds at 4, ser_done stays 0.

Source files
------------

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: captures word and parity, shifts LSB-first, drives the registered line.
// tx_out lags mux_sel by one clk; no backpressure, the FSM paces every bit through ser_en/mux_sel.
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  busy,
  input  logic                  ser_en,
  input  logic [1:0]            mux_sel,
  output logic                  ser_done,
  output logic                  par_en_q,
  output logic                  tx_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_STOP  = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;
  localparam logic [1:0] SEL_PAR   = 2'd3;

  logic [DATA_WIDTH-1:0] r_shift_reg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_par_bit;
  logic                  r_par_en_q;
  logic                  r_tx_out;

  logic w_capture;
  logic w_shift;
  logic w_start;
  logic w_last;
  logic w_tx_sel;

  assign w_capture = data_valid && !busy;
  assign w_shift   = ser_en && (mux_sel == SEL_DATA);
  assign w_start   = ser_en && (mux_sel == SEL_START);
  assign w_last    = (r_bit_cnt == LAST_BIT);

  assign ser_done  = w_shift && w_last;
  assign par_en_q  = r_par_en_q;
  assign tx_out    = r_tx_out;

  always_comb begin
    w_tx_sel = 1'b1;
    case (mux_sel)
      SEL_START: w_tx_sel = 1'b0;
      SEL_STOP:  w_tx_sel = 1'b1;
      SEL_DATA:  w_tx_sel = r_shift_reg[0];
      SEL_PAR:   w_tx_sel = r_par_bit;
    endcase
  end

  // Capture outranks shift/start so a misbehaving FSM can never corrupt a freshly latched word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_par_bit   <= 1'b0;
      r_par_en_q  <= 1'b0;
      r_tx_out    <= 1'b1;
    end else begin
      r_tx_out <= w_tx_sel;
      if (w_capture) begin
        r_shift_reg <= p_data;
        r_par_bit   <= (^p_data) ^ par_typ;
        r_par_en_q  <= par_en;
        r_bit_cnt   <= '0;
      end else if (w_shift) begin
        r_shift_reg <= r_shift_reg >> 1;
        if (!w_last) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (w_start) begin
        r_bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed frames through a bench-emulated fsm_tx; a monitor checks tx_out, ser_done and par_en_q each cycle.
module tb_uart_tx_datapath;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       busy;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       ser_done;
  logic       par_en_q;
  logic       tx_out;

  uart_tx_datapath #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .busy       (busy),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .ser_done   (ser_done),
    .par_en_q   (par_en_q),
    .tx_out     (tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tx;
    logic sd;
    logic pq;
    int   tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_sel;
  logic cur_pq;
  logic drv_done;

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (tx_out !== e.tx) begin
        errors++;
        $display("FAIL t%0d tx_out got %b exp %b @%0t", e.tag, tx_out, e.tx, $time);
      end
      checks++;
      if (ser_done !== e.sd) begin
        errors++;
        $display("FAIL t%0d ser_done got %b exp %b @%0t", e.tag, ser_done, e.sd, $time);
      end
      checks++;
      if (par_en_q !== e.pq) begin
        errors++;
        $display("FAIL t%0d par_en_q got %b exp %b @%0t", e.tag, par_en_q, e.pq, $time);
      end
    end
  end

  // One clock of stimulus; sel is the bit the mux should pick this cycle (shows on tx next cycle).
  task automatic cyc(input logic r, input logic dv, input logic [7:0] pd,
                     input logic pe, input logic pt, input logic b, input logic se,
                     input logic [1:0] ms, input logic sel, input logic exp_sd, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; data_valid = dv; p_data = pd; par_en = pe; par_typ = pt;
    busy = b; ser_en = se; mux_sel = ms;
    e.tx = prev_sel; e.sd = exp_sd; e.pq = cur_pq; e.tag = tag;
    q.push_back(e);
    if (!r) begin
      prev_sel = 1'b1;
      cur_pq   = 1'b0;
    end else begin
      prev_sel = sel;
      if (dv && !b) cur_pq = pe;
    end
  endtask

  // line: hand-computed frame, bit0 = start, bits1..8 = D0..D7, then parity (if any).
  // Config inputs are driven inverted after capture to show they are not re-latched.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [15:0] line, input int stall_at,
                            input int glitch_at, input int abort_at, input int tag);
    cyc(1'b1, 1'b1, d, pe, pt, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, tag);
    cyc(1'b1, 1'b0, 8'h00, !pe, !pt, 1'b1, 1'b1, 2'd0, line[0], 1'b0, tag);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        cyc(1'b0, 1'b0, 8'h00, !pe, !pt, 1'b1, 1'b1, 2'd2, line[i+1], 1'b0, tag);
        return;
      end
      if (i == stall_at) begin
        repeat (3) cyc(1'b1, 1'b0, 8'h00, !pe, !pt, 1'b1, 1'b0, 2'd2, line[i+1], 1'b0, tag);
      end
      cyc(1'b1, (i == glitch_at), (i == glitch_at) ? 8'hC3 : 8'h00, !pe, !pt,
          1'b1, 1'b1, 2'd2, line[i+1], (i == 7), tag);
    end
    if (pe) cyc(1'b1, 1'b0, 8'h00, !pe, !pt, 1'b1, 1'b1, 2'd3, line[9], 1'b0, tag);
    cyc(1'b1, 1'b0, 8'h00, !pe, !pt, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, tag);
  endtask

  task automatic idle(input int n, input int tag);
    repeat (n) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, tag);
  endtask

  initial begin
    drv_done = 1'b0;
    prev_sel = 1'b1;
    cur_pq   = 1'b0;
    rst = 1'b0; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
    busy = 1'b0; ser_en = 1'b0; mux_sel = 2'd1;
    @(posedge clk);
    // Reset state: line idle-high, ser_done low, par_en_q low.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 0);
    idle(2, 0);

    send_frame(8'hA5, 1'b1, 1'b0, 16'h054A, -1, -1, -1, 1);
    send_frame(8'h01, 1'b1, 1'b1, 16'h0402, -1, -1, -1, 2);
    send_frame(8'hFF, 1'b0, 1'b0, 16'h03FE, -1, -1, -1, 3);
    idle(2, 3);
    send_frame(8'h3C, 1'b1, 1'b0, 16'h0478, -1, 2, -1, 4);
    idle(1, 4);

    send_frame(8'h5A, 1'b1, 1'b1, 16'h06B4, -1, -1, 3, 5);
    // After reset: shift_reg[0]=0 and par_bit=0 must reach the line.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 5);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 5);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 5);
    send_frame(8'h5A, 1'b1, 1'b1, 16'h06B4, -1, -1, -1, 5);
    idle(1, 5);

    send_frame(8'h10, 1'b0, 1'b0, 16'h0220, 4, -1, -1, 6);
    idle(3, 6);
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (!drv_done || q.size() != 0) begin
      errors++;
      $display("FAIL drain done=%b pending=%0d exp done=1 pending=0", drv_done, q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
